uart_cmd_decoder: RTL

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: parses A5-framed register-write packets, updates the
// signal-generator parameters and returns a one-byte ACK/NAK over a single-slot response path.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 8680
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxSend,
  input  logic        ipTxBusy,
  output logic [1:0]  opWaveSel,
  output logic [15:0] opFreqWord,
  output logic [15:0] opAmplitude,
  output logic        opUpdate,
  output logic [7:0]  opErrCount,
  output logic        opOverrun
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {WaitSync, GetAddr, GetDataH, GetDataL, GetChk} rx_state_t;
  typedef enum logic [1:0] {TxIdle, TxReq, TxRelease} tx_state_t;

  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  logic          prev_valid_q;
  logic [7:0]    addr_q, addr_d, dh_q, dh_d, dl_q, dl_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    slot_q, slot_d;
  logic          slot_full_q, slot_full_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_send_q, tx_send_d;
  logic [1:0]    wave_q, wave_d;
  logic [15:0]   freq_q, freq_d, amp_q, amp_d;
  logic          update_q, update_d;
  logic [7:0]    err_q, err_d;
  logic          overrun_q, overrun_d;

  logic       strobe, consume, rsp_push, err_inc;
  logic [7:0] rsp_byte;

  assign strobe = ipRxValid & ~prev_valid_q;

  always_comb begin
    rx_state_d = rx_state_q;
    addr_d     = addr_q;
    dh_d       = dh_q;
    dl_d       = dl_q;
    tmo_d      = tmo_q;
    wave_d     = wave_q;
    freq_d     = freq_q;
    amp_d      = amp_q;
    update_d   = 1'b0;
    err_d      = err_q;
    rsp_push   = 1'b0;
    rsp_byte   = '0;
    err_inc    = 1'b0;

    if (strobe) begin
      case (rx_state_q)
        WaitSync: if (ipRxData == SYNC) rx_state_d = GetAddr;
        GetAddr:  begin addr_d = ipRxData; rx_state_d = GetDataH; end
        GetDataH: begin dh_d = ipRxData; rx_state_d = GetDataL; end
        GetDataL: begin dl_d = ipRxData; rx_state_d = GetChk; end
        GetChk: begin
          rx_state_d = WaitSync;
          rsp_push   = 1'b1;
          if ((ipRxData == (addr_q ^ dh_q ^ dl_q)) && (addr_q < 8'd3)) begin
            rsp_byte = ACK;
            update_d = 1'b1;
            case (addr_q[1:0])
              2'd0:    wave_d = dl_q[1:0];
              2'd1:    freq_d = {dh_q, dl_q};
              default: amp_d  = {dh_q, dl_q};
            endcase
          end else begin
            rsp_byte = NAK;
            err_inc  = 1'b1;
          end
        end
        default: rx_state_d = WaitSync;
      endcase
    end

    // A strobe always restarts the inter-byte timer, so it wins over an expiring timeout.
    if (rx_state_q == WaitSync || strobe) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d      = '0;
      rx_state_d = WaitSync;
      err_inc    = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    tx_send_d   = tx_send_q;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;
    overrun_d   = 1'b0;
    consume     = (tx_state_q == TxIdle) && slot_full_q;

    case (tx_state_q)
      TxIdle: if (slot_full_q) begin
        tx_data_d  = slot_q;
        tx_send_d  = 1'b1;
        tx_state_d = TxReq;
      end
      TxReq: if (ipTxBusy) begin
        tx_send_d  = 1'b0;
        tx_state_d = TxRelease;
      end
      TxRelease: if (!ipTxBusy) tx_state_d = TxIdle;
      default: tx_state_d = TxIdle;
    endcase

    if (consume) slot_full_d = 1'b0;
    // A slot emptied by the transmitter this cycle can take the new response directly.
    if (rsp_push) begin
      if (!slot_full_q || consume) begin
        slot_d      = rsp_byte;
        slot_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      rx_state_q   <= WaitSync;
      tx_state_q   <= TxIdle;
      prev_valid_q <= 1'b1;
      addr_q       <= '0;
      dh_q         <= '0;
      dl_q         <= '0;
      tmo_q        <= '0;
      slot_q       <= '0;
      slot_full_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_send_q    <= 1'b0;
      wave_q       <= '0;
      freq_q       <= '0;
      amp_q        <= '0;
      update_q     <= 1'b0;
      err_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      tx_state_q   <= tx_state_d;
      prev_valid_q <= ipRxValid;
      addr_q       <= addr_d;
      dh_q         <= dh_d;
      dl_q         <= dl_d;
      tmo_q        <= tmo_d;
      slot_q       <= slot_d;
      slot_full_q  <= slot_full_d;
      tx_data_q    <= tx_data_d;
      tx_send_q    <= tx_send_d;
      wave_q       <= wave_d;
      freq_q       <= freq_d;
      amp_q        <= amp_d;
      update_q     <= update_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign opTxData    = tx_data_q;
  assign opTxSend    = tx_send_q;
  assign opWaveSel   = wave_q;
  assign opFreqWord  = freq_q;
  assign opAmplitude = amp_q;
  assign opUpdate    = update_q;
  assign opErrCount  = err_q;
  assign opOverrun   = overrun_q;

endmodule
